// File: rtl/video_timing_if.sv
// Video timing bundle: sync position offsets in, pixel enable, counters and
// sync/blank strobes out.
interface video_timing_if;
  logic [3:0] h_adj;
  logic [3:0] v_adj;
  logic       ce_pix;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic       HSync;
  logic       VSync;
  logic       HBlank;
  logic       VBlank;
  logic       frame_start;

  modport master (
    input  h_adj, v_adj,
    output ce_pix, hcnt, vcnt, HSync, VSync, HBlank, VBlank, frame_start
  );

  modport slave (
    output h_adj, v_adj,
    input  ce_pix, hcnt, vcnt, HSync, VSync, HBlank, VBlank, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: divides clk_sys into a pixel enable and produces
// registered pixel/line counters with sync and blanking strobes.
module video_timing_gen #(
  parameter int unsigned CE_DIV       = 4,
  parameter int unsigned H_TOTAL      = 384,
  parameter int unsigned H_ACTIVE     = 256,
  parameter int unsigned H_SYNC_START = 304,
  parameter int unsigned H_SYNC_LEN   = 32,
  parameter int unsigned V_TOTAL      = 264,
  parameter int unsigned V_ACTIVE     = 224,
  parameter int unsigned V_SYNC_START = 240,
  parameter int unsigned V_SYNC_LEN   = 8
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  video_timing_if.master vid
);

  localparam int unsigned DivW = $clog2(CE_DIV);

  localparam logic [DivW-1:0]   DivMax     = DivW'(CE_DIV - 1);
  localparam logic [8:0]        HLast      = 9'(H_TOTAL - 1);
  localparam logic [8:0]        VLast      = 9'(V_TOTAL - 1);
  localparam logic [8:0]        HActive    = 9'(H_ACTIVE);
  localparam logic [8:0]        VActive    = 9'(V_ACTIVE);
  localparam logic signed [9:0] HSyncStart = 10'(H_SYNC_START);
  localparam logic signed [9:0] HSyncLen   = 10'(H_SYNC_LEN);
  localparam logic signed [9:0] VSyncStart = 10'(V_SYNC_START);
  localparam logic signed [9:0] VSyncLen   = 10'(V_SYNC_LEN);

  logic [DivW-1:0] div_q, div_d;
  logic [8:0]      hcnt_q, hcnt_d;
  logic [8:0]      vcnt_q, vcnt_d;
  logic [3:0]      ha_q, ha_d;
  logic [3:0]      va_q, va_d;
  logic            ce_q, ce_d;
  logic            fs_q, fs_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            hb_q, hb_d;
  logic            vb_q, vb_d;

  logic              step;
  logic signed [9:0] hs_lo, vs_lo, h_pos, v_pos;

  assign step = (div_q == DivMax);

  always_comb begin
    div_d  = step ? '0 : div_q + DivW'(1);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    ha_d   = ha_q;
    va_d   = va_q;
    ce_d   = step;
    fs_d   = 1'b0;
    hs_d   = hs_q;
    vs_d   = vs_q;
    hb_d   = hb_q;
    vb_d   = vb_q;
    hs_lo  = '0;
    vs_lo  = '0;
    h_pos  = '0;
    v_pos  = '0;
    if (step) begin
      hcnt_d = (hcnt_q == HLast) ? '0 : hcnt_q + 9'd1;
      if (hcnt_q == HLast) begin
        vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 9'd1;
      end
      fs_d = (hcnt_d == '0) && (vcnt_d == '0);
      // Offsets only take effect at a frame boundary so no sync is ever split.
      if (fs_d) begin
        ha_d = vid.h_adj;
        va_d = vid.v_adj;
      end
      hs_lo = HSyncStart + $signed({{6{ha_d[3]}}, ha_d});
      vs_lo = VSyncStart + $signed({{6{va_d[3]}}, va_d});
      h_pos = $signed({1'b0, hcnt_d});
      v_pos = $signed({1'b0, vcnt_d});
      hs_d  = (h_pos >= hs_lo) && (h_pos < hs_lo + HSyncLen);
      vs_d  = (v_pos >= vs_lo) && (v_pos < vs_lo + VSyncLen);
      hb_d  = (hcnt_d >= HActive);
      vb_d  = (vcnt_d >= VActive);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      hcnt_q <= HLast;
      vcnt_q <= VLast;
      ha_q   <= '0;
      va_q   <= '0;
      ce_q   <= 1'b0;
      fs_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      hb_q   <= 1'b1;
      vb_q   <= 1'b1;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      ha_q   <= ha_d;
      va_q   <= va_d;
      ce_q   <= ce_d;
      fs_q   <= fs_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      hb_q   <= hb_d;
      vb_q   <= vb_d;
    end
  end

  assign vid.ce_pix      = ce_q;
  assign vid.hcnt        = hcnt_q;
  assign vid.vcnt        = vcnt_q;
  assign vid.HSync       = hs_q;
  assign vid.VSync       = vs_q;
  assign vid.HBlank      = hb_q;
  assign vid.VBlank      = vb_q;
  assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default instance for reset/line behaviour, two reduced
// instances so that frame-level behaviour fits in a short run.
module tb_video_timing_gen;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   n_tests = 0;
  int   n_fail  = 0;

  // {ce_pix, frame_start, HSync, VSync, HBlank, VBlank, hcnt, vcnt}
  localparam logic [23:0] RstVec = {6'b000011, 9'd383, 9'd263};

  video_timing_if if_a ();
  video_timing_if if_b ();
  video_timing_if if_c ();

  video_timing_gen u_a (
    .clk_sys (clk),
    .reset_n (rst_a),
    .vid     (if_a)
  );

  // Default horizontal timing, 4-line frames for fast frame-boundary tests.
  video_timing_gen #(
    .CE_DIV       (2),
    .V_TOTAL      (4),
    .V_ACTIVE     (2),
    .V_SYNC_START (2),
    .V_SYNC_LEN   (1)
  ) u_b (
    .clk_sys (clk),
    .reset_n (rst_b),
    .vid     (if_b)
  );

  // Default vertical timing, 32-pixel lines.
  video_timing_gen #(
    .CE_DIV       (2),
    .H_TOTAL      (32),
    .H_ACTIVE     (8),
    .H_SYNC_START (16),
    .H_SYNC_LEN   (4)
  ) u_c (
    .clk_sys (clk),
    .reset_n (rst_c),
    .vid     (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    logic [23:0] obs;
    rst_a = 1'b0;
    if_a.h_adj = 4'd0;
    if_a.v_adj = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    obs = {if_a.ce_pix, if_a.frame_start, if_a.HSync, if_a.VSync, if_a.HBlank, if_a.VBlank,
           if_a.hcnt, if_a.vcnt};
    n_tests++;
    if (obs !== RstVec) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, RstVec);
    end
  endtask

  // Release A and check the first three pixel enables.
  task automatic test_release;
    logic [23:0] obs;
    @(negedge clk);
    rst_a = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      obs = {if_a.ce_pix, if_a.frame_start, if_a.HSync, if_a.VSync, if_a.HBlank, if_a.VBlank,
             if_a.hcnt, if_a.vcnt};
      n_tests++;
      if (if_a.ce_pix !== ((e % 4) == 0)) begin
        n_fail++;
        $display("FAIL ce_pix_edge%0d: got %b expected %b", e, if_a.ce_pix, (e % 4) == 0);
      end
      if (e < 4) begin
        n_tests++;
        if (obs !== RstVec) begin
          n_fail++;
          $display("FAIL pre_step_edge%0d: got %h expected %h", e, obs, RstVec);
        end
      end
      if (e == 4) begin
        n_tests++;
        if (obs !== {6'b110000, 9'd0, 9'd0}) begin
          n_fail++;
          $display("FAIL first_pixel: got %h expected %h", obs, {6'b110000, 9'd0, 9'd0});
        end
      end
      if (e == 8) begin
        n_tests++;
        if (if_a.frame_start !== 1'b0 || if_a.hcnt !== 9'd1) begin
          n_fail++;
          $display("FAIL second_pixel: got fs=%b hcnt=%0d expected fs=0 hcnt=1",
                   if_a.frame_start, if_a.hcnt);
        end
      end
    end
  endtask

  // Continue from hcnt=2 through one full line into the next.
  task automatic test_line;
    int  exp_h = 2;
    int  since = 0;
    int  edges = 0;
    int  hb_rise = -1;
    int  hb_fall = -1;
    int  hs_first = -1;
    int  hs_last = -1;
    int  hs_cnt = 0;
    int  space_err = 0;
    int  track_err = 0;
    int  v_after = -1;
    bit  prev_hb = 1'b0;
    bit  wrapped = 1'b0;
    bit  done = 1'b0;
    while (!done && edges < 2000) begin
      @(posedge clk);
      #1;
      edges++;
      since++;
      if (if_a.ce_pix) begin
        if (since != 4) space_err++;
        since = 0;
        exp_h = (exp_h == 383) ? 0 : exp_h + 1;
        if (int'(if_a.hcnt) != exp_h) track_err++;
        if (if_a.HBlank && !prev_hb && hb_rise < 0) hb_rise = int'(if_a.hcnt);
        if (!if_a.HBlank && prev_hb) hb_fall = int'(if_a.hcnt);
        prev_hb = if_a.HBlank;
        if (if_a.HSync) begin
          if (hs_first < 0) hs_first = int'(if_a.hcnt);
          hs_last = int'(if_a.hcnt);
          hs_cnt++;
        end
        if (exp_h == 0) begin
          wrapped = 1'b1;
          v_after = int'(if_a.vcnt);
        end
        if (wrapped && exp_h == 1) done = 1'b1;
      end
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL line_timeout: got %0d edges", edges); end
    n_tests++;
    if (hb_rise != 256) begin n_fail++; $display("FAIL hblank_rise: got %0d expected 256", hb_rise); end
    n_tests++;
    if (hb_fall != 0) begin n_fail++; $display("FAIL hblank_fall: got %0d expected 0", hb_fall); end
    n_tests++;
    if (hs_first != 304) begin n_fail++; $display("FAIL hsync_first: got %0d expected 304", hs_first); end
    n_tests++;
    if (hs_last != 335) begin n_fail++; $display("FAIL hsync_last: got %0d expected 335", hs_last); end
    n_tests++;
    if (hs_cnt != 32) begin n_fail++; $display("FAIL hsync_width: got %0d expected 32", hs_cnt); end
    n_tests++;
    if (space_err != 0) begin n_fail++; $display("FAIL ce_spacing: got %0d errors expected 0", space_err); end
    n_tests++;
    if (track_err != 0) begin n_fail++; $display("FAIL hcnt_seq: got %0d errors expected 0", track_err); end
    n_tests++;
    if (v_after != 1) begin n_fail++; $display("FAIL vcnt_advance: got %0d expected 1", v_after); end
  endtask

  task automatic test_async_reset;
    logic [23:0] obs;
    int edges = 0;
    bit found = 1'b0;
    while (!found && edges < 2000) begin
      @(posedge clk);
      #1;
      edges++;
      if (if_a.ce_pix && if_a.hcnt == 9'd100) found = 1'b1;
    end
    n_tests++;
    if (!found || if_a.vcnt !== 9'd1) begin
      n_fail++;
      $display("FAIL reach_mid_frame: got found=%b vcnt=%0d expected found=1 vcnt=1",
               found, if_a.vcnt);
    end
    #2;
    rst_a = 1'b0;
    #1;
    obs = {if_a.ce_pix, if_a.frame_start, if_a.HSync, if_a.VSync, if_a.HBlank, if_a.VBlank,
           if_a.hcnt, if_a.vcnt};
    n_tests++;
    if (obs !== RstVec) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", obs, RstVec);
    end
    repeat (5) @(posedge clk);
    test_release();
  endtask

  // h_adj changed mid-frame only moves HSync from the following frame on.
  task automatic test_hadj;
    int first[3];
    int last[3];
    int exp_first[3];
    int exp_last[3];
    int frame = -1;
    int edges = 0;
    exp_first[0] = 304; exp_last[0] = 335;
    exp_first[1] = 296; exp_last[1] = 327;
    exp_first[2] = 311; exp_last[2] = 342;
    for (int i = 0; i < 3; i++) begin
      first[i] = -1;
      last[i] = -1;
    end
    if_b.h_adj = 4'd0;
    if_b.v_adj = 4'd0;
    @(negedge clk);
    rst_b = 1'b1;
    while (frame < 3 && edges < 12000) begin
      @(posedge clk);
      #1;
      edges++;
      if (if_b.ce_pix) begin
        if (if_b.frame_start) frame++;
        if (frame >= 0 && frame < 3) begin
          if (if_b.vcnt == 9'd2 && if_b.hcnt == 9'd0) if_b.h_adj = (frame == 0) ? 4'b1000 : 4'd7;
          if (if_b.vcnt == 9'd3 && if_b.HSync) begin
            if (first[frame] < 0) first[frame] = int'(if_b.hcnt);
            last[frame] = int'(if_b.hcnt);
          end
        end
      end
    end
    n_tests++;
    if (frame < 3) begin n_fail++; $display("FAIL hadj_timeout: got %0d frames expected 3", frame); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (first[i] != exp_first[i] || last[i] != exp_last[i]) begin
        n_fail++;
        $display("FAIL hadj_frame%0d: got %0d..%0d expected %0d..%0d", i, first[i], last[i],
                 exp_first[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_vertical;
    int vb_first = -1;
    int vb_last = -1;
    int vs_first[2];
    int vs_last[2];
    int fs_edge[3];
    int frame = -1;
    int edges = 0;
    int vs_bad = 0;
    bit prev_vs = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vs_first[i] = -1;
      vs_last[i] = -1;
    end
    for (int i = 0; i < 3; i++) fs_edge[i] = -1;
    if_c.h_adj = 4'd0;
    if_c.v_adj = 4'd0;
    @(negedge clk);
    rst_c = 1'b1;
    while (frame < 2 && edges < 40000) begin
      @(posedge clk);
      #1;
      edges++;
      if (if_c.ce_pix) begin
        if (if_c.frame_start) begin
          frame++;
          fs_edge[frame] = edges;
        end
        if (if_c.VSync != prev_vs && if_c.hcnt != 9'd0) vs_bad++;
        prev_vs = if_c.VSync;
        if (frame == 0 && if_c.vcnt == 9'd100 && if_c.hcnt == 9'd0) if_c.v_adj = 4'd7;
        if (frame == 0 && if_c.VBlank) begin
          if (vb_first < 0) vb_first = int'(if_c.vcnt);
          vb_last = int'(if_c.vcnt);
        end
        if (frame >= 0 && frame < 2 && if_c.VSync) begin
          if (vs_first[frame] < 0) vs_first[frame] = int'(if_c.vcnt);
          vs_last[frame] = int'(if_c.vcnt);
        end
      end
    end
    n_tests++;
    if (frame < 2) begin n_fail++; $display("FAIL vert_timeout: got %0d frames expected 2", frame); end
    n_tests++;
    if (fs_edge[1] - fs_edge[0] != 16896) begin
      n_fail++;
      $display("FAIL frame_period: got %0d expected 16896", fs_edge[1] - fs_edge[0]);
    end
    n_tests++;
    if (vb_first != 224 || vb_last != 263) begin
      n_fail++;
      $display("FAIL vblank_span: got %0d..%0d expected 224..263", vb_first, vb_last);
    end
    n_tests++;
    if (vs_first[0] != 240 || vs_last[0] != 247) begin
      n_fail++;
      $display("FAIL vsync_frame0: got %0d..%0d expected 240..247", vs_first[0], vs_last[0]);
    end
    n_tests++;
    if (vs_first[1] != 247 || vs_last[1] != 254) begin
      n_fail++;
      $display("FAIL vsync_frame1: got %0d..%0d expected 247..254", vs_first[1], vs_last[1]);
    end
    n_tests++;
    if (vs_bad != 0) begin n_fail++; $display("FAIL vsync_mid_line: got %0d expected 0", vs_bad); end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    if_a.h_adj = 4'd0;
    if_a.v_adj = 4'd0;
    if_b.h_adj = 4'd0;
    if_b.v_adj = 4'd0;
    if_c.h_adj = 4'd0;
    if_c.v_adj = 4'd0;
    test_reset();
    test_release();
    test_line();
    test_async_reset();
    test_hadj();
    test_vertical();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter CE_DIV, 4, clk_sys cycles per pixel (≥2).
REQ-002 Parameter H_TOTAL, 384, pixels per line including blanking.
REQ-003 Parameter H_ACTIVE, 256, visible pixels per line.
REQ-004 Parameter H_SYNC_START, 304, nominal first HSync pixel.
REQ-005 Parameter H_SYNC_LEN, 32, HSync width in pixels.
REQ-006 Parameter V_TOTAL, 264, lines per frame.
REQ-007 Parameter V_ACTIVE, 224, visible lines.
REQ-008 Parameter V_SYNC_START, 240, nominal first VSync line.
REQ-009 Parameter V_SYNC_LEN, 8, VSync height in lines.
REQ-010 clk_sys  input  1  master clock; the only clock in the block.
REQ-011 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-012 h_adj  input  4  signed HSync position offset, -8..+7 pixels.
REQ-013 v_adj  input  4  signed VSync position offset, -8..+7 lines.
REQ-014 ce_pix  output  1  one-clk pixel enable pulse.
REQ-015 hcnt  output  9  current pixel column.
REQ-016 vcnt  output  9  current line.
REQ-017 HSync, VSync, HBlank, VBlank  output  1 each  positive pulses, mixer-compatible.
REQ-018 frame_start  output  1  one-clk pulse marking pixel (0,0).

Function
REQ-019 Internal divider div counts 0..CE_DIV-1 on every clk_sys edge and wraps to 0.
REQ-020 On the edge where div==CE_DIV-1 ("step"), ce_pix SHALL be set to 1; on all other edges it SHALL be set to 0.
REQ-021 On a step, hcnt SHALL advance by 1, wrapping from H_TOTAL-1 to 0; on that wrap vcnt SHALL advance by 1, wrapping from V_TOTAL-1 to 0.
REQ-022 All outputs SHALL be registered and updated only on step edges, decoded from the new counter values, so that they are valid whenever ce_pix is high.
REQ-023 HBlank = (hcnt ≥ H_ACTIVE); VBlank = (vcnt ≥ V_ACTIVE).
REQ-024 HSync = (hcnt ≥ H_SYNC_START+ha) and (hcnt < H_SYNC_START+ha+H_SYNC_LEN), where ha is the latched sign-extended h_adj; all arithmetic is 10-bit signed.
REQ-025 VSync = (vcnt ≥ V_SYNC_START+va) and (vcnt < V_SYNC_START+va+V_SYNC_LEN), where va is the latched v_adj; therefore VSync changes only at hcnt==0.
REQ-026 h_adj and v_adj SHALL be latched into ha/va only on the step that enters (0,0), so mid-frame changes never produce a partial or doubled sync.
REQ-027 frame_start SHALL be 1 exactly on the step entering (0,0) and 0 otherwise.
REQ-028 Sync windows SHALL lie entirely inside blanking for every adj value; the defaults satisfy this, and other parameter sets are the integrator's responsibility.
REQ-029 Extreme offsets: with h_adj=-8 (4'b1000), HSync spans columns 296..327; with h_adj=+7, it spans columns 311..342.

Reset
REQ-030 While reset_n is low: div=0, hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, ha=va=0, ce_pix=0, frame_start=0, HSync=0, VSync=0, HBlank=1, VBlank=1.
REQ-031 After release, the first step occurs on the CE_DIV-th rising edge. That step presents pixel (0,0) with frame_start=1, HBlank=0 and VBlank=0.
REQ-032 Reset asserted mid-frame SHALL return all state to the REQ-030 values immediately, without waiting for a clock; no glitch pulse is produced on release.

Verification
REQ-033 Release reset, defaults -> ce_pix on edges 4, 8, 12, ...; first ce_pix with hcnt=0, vcnt=0 and frame_start=1.
REQ-034 Run 1 line -> HBlank rises at hcnt=256; HSync high for hcnt 304..335 (32 ce_pix); HBlank falls at the next hcnt=0.
REQ-035 Run 1 frame -> VBlank high for vcnt 224..263; VSync high for vcnt 240..247; frame_start period = 384*264*4 = 405504 clk_sys.
REQ-036 Set h_adj=-8, v_adj=+7 mid-frame -> current frame unchanged; the next frame has HSync at 296..327 and VSync at 247..254.
REQ-037 Assert reset_n low at hcnt=100, vcnt=50 -> outputs take the REQ-030 values asynchronously; after release, REQ-033 repeats exactly.
